// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtraction controller.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/FullSubtractor.sv
// Single-bit full subtractor: diff = a - b - b_in, with borrow out.
module FullSubtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic diff,
    output logic b_out
);

    assign diff  = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B controller: one shared 1-bit subtractor stepped LSB first over WIDTH cycles.
//
//   state | meaning
//   IDLE  | ready for a request, result outputs held
//   RUN   | one operand bit per cycle through the subtractor cell
//   DONE  | one-cycle done pulse, diff/borrow_out valid
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_d;
    logic [WIDTH-1:0] sh_d_nxt;
    logic [CNT_W-1:0] cnt;
    logic             brw;
    logic             cell_diff;
    logic             cell_bout;
    logic             last_bit;

    FullSubtractor u_cell (
        .a     (sh_a[0]),
        .b     (sh_b[0]),
        .b_in  (brw),
        .diff  (cell_diff),
        .b_out (cell_bout)
    );

    // Result bits enter at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    assign sh_d_nxt = (sh_d >> 1) | (WIDTH'(cell_diff) << (WIDTH - 1));
    assign last_bit = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a       <= '0;
            sh_b       <= '0;
            sh_d       <= '0;
            cnt        <= '0;
            brw        <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a <= a;
                        sh_b <= b;
                        sh_d <= '0;
                        cnt  <= '0;
                        brw  <= 1'b0;
                    end
                end
                RUN: begin
                    sh_a <= sh_a >> 1;
                    sh_b <= sh_b >> 1;
                    sh_d <= sh_d_nxt;
                    brw  <= cell_bout;
                    cnt  <= cnt + 1'b1;
                    // Capture on the last step so the result is already valid while done is high.
                    if (last_bit) begin
                        diff       <= sh_d_nxt;
                        borrow_out <= cell_bout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl: 8-bit vectors, corner sequences, exhaustive 4-bit sweep.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ready8, busy8, done8, borrow8;
    logic [7:0] diff8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       ready4, busy4, done4, borrow4;
    logic [3:0] diff4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       br;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .ready      (ready8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (borrow8)
    );

    serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .a          (a4),
        .b          (b4),
        .ready      (ready4),
        .busy       (busy4),
        .done       (done4),
        .diff       (diff4),
        .borrow_out (borrow4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_op8(input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb);
        int edges;
        int rdy_low;
        @(negedge clk);
        chk("op ready before start", 32'(ready8), 32'd1);
        a8 = av; b8 = bv; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~av; b8 = ~bv;
        chk("op busy after accept", 32'(busy8), 32'd1);
        edges = 0;
        rdy_low = 0;
        while (!done8 && edges < 40) begin
            if (!ready8) rdy_low++;
            @(negedge clk);
            edges++;
        end
        if (!ready8) rdy_low++;
        chk("op latency", 32'(edges), 32'd8);
        chk("op ready low cycles", 32'(rdy_low), 32'd9);
        chk("op diff", 32'(diff8), 32'(ed));
        chk("op borrow", 32'(borrow8), 32'(eb));
        @(negedge clk);
        chk("op done width", 32'(done8), 32'd0);
        chk("op ready after done", 32'(ready8), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int         edges;
        int         ndone;
        int         nbad;
        logic [3:0] ai, bi, ed4;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[4] = '{8'h10, 8'h01, 8'h0F, 1'b0};
        vecs[5] = '{8'h80, 8'h01, 8'h7F, 1'b0};
        vecs[6] = '{8'hA5, 8'h5A, 8'h4B, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[8] = '{8'h01, 8'hFF, 8'h02, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset ready", 32'(ready8), 32'd1);
        chk("reset busy", 32'(busy8), 32'd0);
        chk("reset done", 32'(done8), 32'd0);
        chk("reset diff", 32'(diff8), 32'd0);
        chk("reset borrow", 32'(borrow8), 32'd0);
        chk("reset ready w4", 32'(ready4), 32'd1);

        for (int i = 0; i < 9; i++)
            do_op8(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br);

        // Second request during RUN must be dropped.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        edges = 0;
        while (!done8 && edges < 40) begin
            if (edges == 3) begin
                a8 = 8'h00; b8 = 8'hFF; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        start8 = 1'b0;
        chk("ignore latency", 32'(edges), 32'd8);
        chk("ignore diff", 32'(diff8), 32'h0F);
        chk("ignore borrow", 32'(borrow8), 32'd0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("ignore extra done", 32'(ndone), 32'd0);
        chk("ignore ready", 32'(ready8), 32'd1);
        chk("ignore diff held", 32'(diff8), 32'h0F);

        // Reset in the middle of RUN aborts without a done pulse.
        a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        edges = 0;
        while (edges < 3) begin
            @(negedge clk);
            edges++;
        end
        chk("abort busy before rst", 32'(busy8), 32'd1);
        chk("abort done before rst", 32'(done8), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort done", 32'(done8), 32'd0);
        chk("abort ready", 32'(ready8), 32'd1);
        chk("abort busy", 32'(busy8), 32'd0);
        chk("abort diff", 32'(diff8), 32'd0);
        chk("abort borrow", 32'(borrow8), 32'd0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("abort no late done", 32'(ndone), 32'd0);
        do_op8(8'h80, 8'h01, 8'h7F, 1'b0);

        // Result holds while operands wiggle and start stays low.
        do_op8(8'h05, 8'h03, 8'h02, 1'b0);
        ndone = 0;
        nbad = 0;
        for (int k = 0; k < 20; k++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            @(negedge clk);
            if (done8) ndone++;
            if (diff8 !== 8'h02) nbad++;
        end
        chk("hold done count", 32'(ndone), 32'd0);
        chk("hold diff changes", 32'(nbad), 32'd0);
        chk("hold diff", 32'(diff8), 32'h02);

        // Exhaustive 4-bit sweep with back-to-back requests.
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            ai = 4'(i >> 4);
            bi = 4'(i);
            ed4 = ai - bi;
            a4 = ai; b4 = bi; start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
            edges = 0;
            while (!done4 && edges < 20) begin
                @(negedge clk);
                edges++;
            end
            chk("w4 latency", 32'(edges), 32'd4);
            chk("w4 diff", 32'(diff4), 32'(ed4));
            chk("w4 borrow", 32'(borrow4), 32'(ai < bi));
            @(negedge clk);
            chk("w4 done width", 32'(done4), 32'd0);
            chk("w4 ready", 32'(ready4), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
